regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 102 ++++++++++
 tb/tb_regfile.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile -- multi-ported register file with one write port and two
// combinational read ports.
//
// Holds COUNT registers of WIDTH bits. Ports A and B read the selected
// register with zero-cycle latency. Port D writes on the rising clock
// edge when we_d is high. A read of the address being written returns the
// old contents until the write edge (no bypass). Addresses >= COUNT read as
// zero and writes to them are dropped.
//
// Ports:
//   clk     in   clock; all state changes on the rising edge
//   rst     in   synchronous active-high reset; clears every register and
//                wins over a write on the same edge
//   addr_a  in   read address, port A
//   addr_b  in   read address, port B
//   addr_d  in   write address, port D
//   we_d    in   write enable, port D
//   d       in   write data, port D
//   a       out  read data, port A
//   b       out  read data, port B
//
// Build option:
//   REGFILE_ZERO_REG_EN  when defined, register 0 is hardwired to zero:
//                        writes to it are dropped and it always reads 0.
//                        When undefined, register 0 is an ordinary register.

module regfile #(
  parameter int COUNT = 32,
  parameter int WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_d,
  input  logic                  we_d,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      a,
  output logic [WIDTH-1:0]      b
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // Current contents of every register, flattened for the read muxes.
  logic [COUNT-1:0][WIDTH-1:0] reg_vals;

  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_reg
      if (ZERO_REG_EN && (gi == 0)) begin : g_zero
        // Hardwired zero: no storage, writes have nothing to land in.
        assign reg_vals[gi] = '0;
      end else begin : g_store
        logic             wr_hit;
        logic [WIDTH-1:0] val_d;
        logic [WIDTH-1:0] val_q;

        // Only an in-range address can match, because gi < COUNT; writes
        // to addresses >= COUNT therefore hit nothing and are dropped.
        always_comb begin
          wr_hit = we_d && (addr_d == ADDR_WIDTH'(gi));
          val_d  = val_q;
          if (wr_hit) begin
            val_d = d;
          end
        end

        // Reset is checked first so it overrides a same-edge write.
        always_ff @(posedge clk) begin
          if (rst) begin
            val_q <= '0;
          end else begin
            val_q <= val_d;
          end
        end

        assign reg_vals[gi] = val_q;
      end
    end
  endgenerate

  // Read muxes read the stored flops directly, so a write becomes visible
  // only after its edge. An out-of-range address matches no entry and the
  // zero default is returned.
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (addr_a == ADDR_WIDTH'(i)) begin
        a = reg_vals[i];
      end
      if (addr_b == ADDR_WIDTH'(i)) begin
        b = reg_vals[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile -- self-checking bench for regfile.
//
// Uses a non-power-of-2 COUNT so out-of-range addresses exist. A reference
// array is updated from the register file's rules on every rising edge, and a
// compare process checks both read ports against it on every falling edge.
// Directed steps add literal checks shortly after inputs change.

module tb_regfile;

  localparam int COUNT = 24;
  localparam int WIDTH = 32;
  localparam int AW    = $clog2(COUNT);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [AW-1:0]    addr_a;
  logic [AW-1:0]    addr_b;
  logic [AW-1:0]    addr_d;
  logic             we_d;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [WIDTH-1:0] mem [COUNT];

  regfile #(.COUNT(COUNT), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_d (addr_d),
    .we_d   (we_d),
    .d      (d),
    .a      (a),
    .b      (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what any address must read from the stored contents.
  function automatic logic [WIDTH-1:0] model_rd(input int addr);
    if (addr >= COUNT) return '0;
    if (ZERO && addr == 0) return '0;
    return mem[addr];
  endfunction

  // Reference model: state change on a rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) mem[i] = '0;
    end else if (we_d && int'(addr_d) < COUNT && !(ZERO && addr_d == 0)) begin
      mem[int'(addr_d)] = d;
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_a", a, model_rd(int'(addr_a)));
      chk("cmp_b", b, model_rd(int'(addr_b)));
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_one(input int addr, input logic [WIDTH-1:0] val);
    tick();
    we_d   = 1'b1;
    addr_d = AW'(addr);
    d      = val;
    tick();
    we_d   = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we_d = 1'b0; addr_a = '0; addr_b = '0; addr_d = '0; d = '0;
    tick();
    tick();
    rst = 1'b0;
    check_en = 1'b1;

    // Reset state, including out-of-range addresses.
    for (int i = 0; i < (1 << AW); i++) begin
      addr_a = AW'(i);
      addr_b = AW'((1 << AW) - 1 - i);
      #1;
      chk("reset_a", a, 32'h0);
      chk("reset_b", b, 32'h0);
      tick();
    end

    // Write i to register i, then read it back without a clock edge.
    for (int i = 0; i < COUNT; i++) begin
      write_one(i, 32'(i));
      addr_a = AW'(i);
      addr_b = AW'(i);
      #1;
      chk("wr_rd_a", a, (ZERO && i == 0) ? 32'h0 : 32'(i));
      chk("wr_rd_b", b, (ZERO && i == 0) ? 32'h0 : 32'(i));
    end

    // Read all with ports A and B on mirrored addresses.
    for (int i = 0; i < COUNT; i++) begin
      tick();
      addr_a = AW'(i);
      addr_b = AW'(COUNT - 1 - i);
      #1;
      chk("all_a", a, (ZERO && i == 0) ? 32'h0 : 32'(i));
      chk("all_b", b, (ZERO && i == COUNT - 1) ? 32'h0 : 32'(COUNT - 1 - i));
    end

    // Out-of-range write must be dropped and must not alias a low register.
    write_one(27, 32'hAAAA_5555);
    addr_a = AW'(27);
    addr_b = AW'(27 - 16);
    #1;
    chk("oor_rd", a, 32'h0);
    chk("oor_alias", b, 32'd11);

    // Both ports on the address being written: old value, then new value.
    tick();
    addr_a = AW'(7); addr_b = AW'(7);
    we_d = 1'b1; addr_d = AW'(7); d = 32'h0000_0077;
    #1;
    chk("same_pre_a", a, 32'd7);
    chk("same_pre_b", b, 32'd7);
    tick();
    we_d = 1'b0;
    #1;
    chk("same_post_a", a, 32'h77);
    chk("same_post_b", b, 32'h77);

    // No bypass, then enable gating.
    do_reset();
    addr_a = AW'(5); addr_b = AW'(6);
    we_d = 1'b1; addr_d = AW'(5); d = 32'hDEAD_BEEF;
    #1;
    chk("nobyp_pre", a, 32'h0);
    tick();
    chk("nobyp_post", a, 32'hDEAD_BEEF);
    we_d = 1'b0; d = 32'h0000_1234;
    tick();
    chk("we_gate", a, 32'hDEAD_BEEF);
    chk("we_gate_other", b, 32'h0);

    // Reset wins over a same-edge write.
    write_one(3, 32'h55);
    addr_a = AW'(3);
    #1;
    chk("pre_rst_prio", a, 32'h55);
    rst = 1'b1; we_d = 1'b1; addr_d = AW'(3); d = 32'h7;
    tick();
    rst = 1'b0; we_d = 1'b0;
    #1;
    chk("rst_prio", a, 32'h0);

    // Reset asserted between edges does nothing until the edge.
    write_one(2, 32'h99);
    addr_a = AW'(2);
    rst = 1'b1;
    #1;
    chk("rst_sync_pre", a, 32'h99);
    tick();
    rst = 1'b0;
    chk("rst_sync_post", a, 32'h0);

    // Register 0 behaviour depends on the build option.
    write_one(0, 32'hFF);
    addr_a = AW'(0);
    #1;
    chk("zero_reg", a, ZERO ? 32'h0 : 32'hFF);

    tick();
    tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
